// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I funct3 codes,
// legality and alignment checks.
package lsu_pkg;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3)
         F3_H, F3_HU: return addr_lo[0];
         F3_W:        return addr_lo != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

   // Stores only exist as SB/SH/SW, so any store with funct3[2] set is illegal.
   function automatic logic illegal_op(input logic we, input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_H, F3_W: return 1'b0;
         F3_BU, F3_HU:     return we;
         default:          return 1'b1;
      endcase
   endfunction

   function automatic logic [1:0] force_align(input logic [2:0] funct3, input logic [1:0] addr_lo);
      case (funct3)
         F3_H, F3_HU: return {addr_lo[1], 1'b0};
         F3_W:        return 2'b00;
         default:     return addr_lo;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: selects the byte/halfword lane from a raw memory word
// and sign- or zero-extends it according to funct3.
module load_align
   import lsu_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic [2:0]        funct3,
   input  logic [1:0]        addr_lo,
   input  logic [DWIDTH-1:0] rdata,
   output logic [DWIDTH-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    data = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
         F3_BU:   data = {{(DWIDTH-8){1'b0}}, byte_sel};
         F3_H:    data = {{(DWIDTH-16){half_sel[15]}}, half_sel};
         F3_HU:   data = {{(DWIDTH-16){1'b0}}, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the ALU and data memory.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing alignment.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [DWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [DWIDTH-1:0] mem_addr,
   output logic              mem_we,
   output logic [3:0]        mem_wstrb,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic              mem_rsp_valid,
   input  logic [DWIDTH-1:0] mem_rdata,
   output logic              rsp_valid,
   output logic [DWIDTH-1:0] rsp_data,
   output logic              rsp_err
);

   lsu_state_t        state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [DWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;
   logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic [DWIDTH-1:0] load_data;
   logic              req_bad;
   logic [1:0]        req_lo;
   logic              in_req;

   load_align #(.DWIDTH(DWIDTH)) u_load_align (
      .funct3  (funct3_q),
      .addr_lo (addr_q[1:0]),
      .rdata   (mem_rdata),
      .data    (load_data)
   );

   // Trap build rejects misaligned ops; default build clears the offending low bits at capture.
   always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
      req_bad = illegal_op(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
      req_lo  = req_addr[1:0];
`else
      req_bad = illegal_op(req_we, req_funct3);
      req_lo  = force_align(req_funct3, req_addr[1:0]);
`endif
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      funct3_d   = funct3_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      case (state_q)
         IDLE: if (req_valid) begin
            we_d       = req_we;
            funct3_d   = req_funct3;
            addr_d     = {req_addr[DWIDTH-1:2], req_lo};
            wdata_d    = req_wdata;
            rsp_data_d = '0;
            rsp_err_d  = req_bad;
            state_d    = req_bad ? DONE : REQ;
         end
         REQ:  if (mem_req_ready) state_d = WAIT;
         WAIT: if (mem_rsp_valid) begin
            rsp_data_d = we_q ? '0 : load_data;
            state_d    = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         funct3_q   <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         funct3_q   <= funct3_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   always_comb begin
      in_req        = (state_q == REQ);
      req_ready     = (state_q == IDLE);
      mem_req_valid = in_req;
      mem_addr      = in_req ? {addr_q[DWIDTH-1:2], 2'b00} : '0;
      mem_we        = in_req && we_q;
      mem_wstrb     = '0;
      mem_wdata     = '0;
      if (in_req && we_q) begin
         case (funct3_q)
            F3_B: begin
               mem_wstrb = 4'b0001 << addr_q[1:0];
               mem_wdata = {4{wdata_q[7:0]}};
            end
            F3_H: begin
               mem_wstrb = 4'b0011 << {addr_q[1], 1'b0};
               mem_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
               mem_wstrb = 4'hF;
               mem_wdata = wdata_q;
            end
         endcase
      end
      rsp_valid = (state_q == DONE);
      rsp_data  = rsp_valid ? rsp_data_q : '0;
      rsp_err   = rsp_valid && rsp_err_q;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized ops
// compared against a byte-lane arithmetic reference model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        mem_req_valid, mem_req_ready, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        mem_rsp_valid;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_data;

   int unsigned chk_cnt  = 0;
   int unsigned pass_cnt = 0;

   always #5 clk = ~clk;

   load_store_unit #(.DWIDTH(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_funct3    (req_funct3),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_we        (mem_we),
      .mem_wstrb     (mem_wstrb),
      .mem_wdata     (mem_wdata),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rdata     (mem_rdata),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   function automatic int unsigned op_size(input logic [2:0] f3);
      return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit trap_on();
`ifdef LSU_MISALIGN_TRAP_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      bit legal;
      legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 1'b1;
      return trap_on() && ((addr % op_size(f3)) != 0);
   endfunction

   function automatic int unsigned eff_off(input logic [2:0] f3, input logic [31:0] addr);
      int unsigned off = addr % 4;
      return off - (off % op_size(f3));
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
      int unsigned sz = op_size(f3);
      longint v;
      if (sz == 4) return word;
      v = longint'((word >> (8 * eff_off(f3, addr))) & ((32'd1 << (8 * sz)) - 1));
      if (!f3[2] && v >= (longint'(1) << (8 * sz - 1))) v -= (longint'(1) << (8 * sz));
      return 32'(v);
   endfunction

   function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
      return 4'(((1 << op_size(f3)) - 1) << eff_off(f3, addr));
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r = '0;
      for (int unsigned k = 0; k < 4; k++)
         r = r | (((wd >> (8 * (k % op_size(f3)))) & 32'hFF) << (8 * k));
      return r;
   endfunction

   // ---------------- op driver ----------------
   task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int unsigned req_stall, input int unsigned rsp_delay);
      bit          err;
      logic [31:0] exp_data;
      err      = model_err(we, f3, addr);
      exp_data = (err || we) ? 32'd0 : model_load(f3, addr, rd);
      check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      if (!err) begin
         for (int unsigned i = 0; i <= req_stall; i++) begin
            mem_req_ready = (i == req_stall);
            check({tag, ".mem_req_valid"}, 32'(mem_req_valid), 32'd1);
            check({tag, ".mem_addr"}, mem_addr, addr & ~32'd3);
            check({tag, ".mem_we"}, 32'(mem_we), 32'(we));
            check({tag, ".mem_wstrb"}, 32'(mem_wstrb), we ? 32'(model_strb(f3, addr)) : 32'd0);
            if (we) check({tag, ".mem_wdata"}, mem_wdata, model_wdata(f3, wd));
            check({tag, ".busy"}, 32'(req_ready), 32'd0);
            @(negedge clk);
         end
         mem_req_ready = 1'b0;
         check({tag, ".wait_no_req"}, 32'(mem_req_valid), 32'd0);
         for (int unsigned i = 0; i < rsp_delay; i++) begin
            mem_rdata = $urandom;
            @(negedge clk);
            check({tag, ".no_early_rsp"}, 32'(rsp_valid), 32'd0);
         end
         mem_rsp_valid = 1'b1; mem_rdata = rd;
         @(negedge clk);
         mem_rsp_valid = 1'b0; mem_rdata = $urandom;
      end else begin
         check({tag, ".err_no_mem"}, 32'(mem_req_valid), 32'd0);
      end
      check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".rsp_err"}, 32'(rsp_err), 32'(err));
      check({tag, ".rsp_data"}, rsp_data, exp_data);
      @(negedge clk);
      check({tag, ".rsp_once"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0;
      req_wdata = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      check("rst.req_ready", 32'(req_ready), 32'd1);
      check("rst.mem_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst.mem_wstrb", 32'(mem_wstrb), 32'd0);
      check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst.rsp_data", rsp_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op("lw",   1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
      do_op("lb",   1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, 1);
      do_op("lbu",  1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFFFF, 1, 0);
      do_op("lhu",  1'b0, 3'b101, 32'h102, 32'h0, 32'h80FFFFFF, 0, 0);
      do_op("lh",   1'b0, 3'b001, 32'h102, 32'h0, 32'h80FFFFFF, 0, 2);
      do_op("sb",   1'b1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 0, 0);
      do_op("sh",   1'b1, 3'b001, 32'h202, 32'h1234CDEF, 32'h0, 0, 0);
      do_op("sw",   1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 0, 0);
      do_op("stall",1'b0, 3'b010, 32'h300, 32'h0, 32'h01234567, 3, 0);
      do_op("lw_mis",1'b0, 3'b010, 32'h102, 32'h0, 32'hA5A55A5A, 0, 0);
      do_op("sh_mis",1'b1, 3'b001, 32'h203, 32'h0000BEEF, 32'h0, 0, 0);
      do_op("ill011",1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
      do_op("ill_sbu",1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0);

      // Reset while waiting on the memory response, then a stale response.
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400;
      @(negedge clk);
      req_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rstmid.req_ready", 32'(req_ready), 32'd1);
      check("rstmid.mem_req_valid", 32'(mem_req_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'h55AA55AA;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      check("stale.rsp_valid", 32'(rsp_valid), 32'd0);
      check("stale.req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      check("stale.rsp_valid2", 32'(rsp_valid), 32'd0);
      do_op("post_rst_lw", 1'b0, 3'b010, 32'h500, 32'h0, 32'h13579BDF, 0, 0);

      for (int unsigned n = 0; n < 200; n++) begin
         do_op("rand", 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
